ram_write_arbiter: RTL

// - Shares the single write port of the board RAM (depth x width, async read,

---
 rtl/ram_write_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/ram_write_arbiter.sv
// Write-port arbiter for the board RAM: two requesters plus a clear sweep.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority.
module ram_write_arbiter #(
    parameter  int depth     = 256,
    parameter  int width     = 10,
    localparam int depthbits = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 ClearStart,
    input  logic [width-1:0]     ClearData,
    output logic                 Busy,
    output logic                 ClearDone,
    input  logic                 ReqA,
    input  logic [depthbits-1:0] AddrA,
    input  logic [width-1:0]     DataA,
    input  logic                 ReqB,
    input  logic [depthbits-1:0] AddrB,
    input  logic [width-1:0]     DataB,
    output logic                 GntA,
    output logic                 GntB,
    output logic                 WE,
    output logic [depthbits-1:0] WAddr,
    output logic [width-1:0]     WData
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [depthbits-1:0] lastaddr = depthbits'(depth - 1);

    state_t               state;
    logic [depthbits-1:0] count;
    logic [width-1:0]     fill;
    logic                 wina;
    logic                 winb;
    logic                 open;

`ifdef RAM_ARB_RR_EN
    logic prefa;
    assign wina = ReqA & (prefa | ~ReqB);
`else
    assign wina = ReqA;
`endif
    assign winb = ReqB & ~wina;

    // A clear request owns the port in its own cycle, so no grant then.
    assign open = (state == IDLE) & ~ClearStart;
    assign GntA = open & wina;
    assign GntB = open & winb;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= IDLE;
            WE        <= 1'b0;
            WAddr     <= '0;
            WData     <= '0;
            Busy      <= 1'b0;
            ClearDone <= 1'b0;
            count     <= '0;
            fill      <= '0;
`ifdef RAM_ARB_RR_EN
            prefa     <= 1'b1;
`endif
        end else begin
            WE        <= 1'b0;
            ClearDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ClearStart) begin
                        state <= CLEAR;
                        Busy  <= 1'b1;
                        count <= '0;
                        fill  <= ClearData;
                    end else if (GntA | GntB) begin
                        WE    <= 1'b1;
                        WAddr <= GntA ? AddrA : AddrB;
                        WData <= GntA ? DataA : DataB;
                    end
                end
                CLEAR: begin
                    WE    <= 1'b1;
                    WAddr <= count;
                    WData <= fill;
                    count <= count + 1'b1;
                    if (count == lastaddr) begin
                        state     <= IDLE;
                        Busy      <= 1'b0;
                        ClearDone <= 1'b1;
                        count     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef RAM_ARB_RR_EN
            if (GntA) begin
                prefa <= 1'b0;
            end else if (GntB) begin
                prefa <= 1'b1;
            end
`endif
        end
    end

endmodule
